ultrasonic_ranger: RTL and testbench
====================================

ULTRASONIC_RANGER -- requirements
Module: ultrasonic_ranger

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 250, trigger pulse width in clk cycles (10 us at 25 MHz).
REQ-002 SHALL have parameter PERIOD_CYCLES, default 1500000, trigger-start to trigger-start spacing (60 ms).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 750000, echo wait/measure limit (30 ms).
REQ-004 SHALL have parameter CM_DIV, default 1450, clk cycles per cm of range (58 us x 25 MHz).
REQ-005 SHALL have ports: clk input 1, system clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: ena input 1, run enable; echo_in input 1, asynchronous HC-SR04 ECHO.
REQ-007 SHALL have ports: trig_out output 1, HC-SR04 TRIGGER, registered.
REQ-008 SHALL have ports: distance_cm output 8, last result, held; dist_valid output 1, one-cycle new-result strobe; dist_err output 1, one-cycle timeout strobe; busy output 1, high in TRIG/WAIT_ECHO/MEASURE.

Function
REQ-009 SHALL synchronise echo_in through two flops; all echo decisions use the synchronised value and its registered previous value (rise/fall detect).
REQ-010 SHALL implement FSM IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF.
REQ-011 IDLE: ena=1 -> TRIG next cycle; period counter cleared on TRIG entry.
REQ-012 TRIG: trig_out=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO; trig_out=0 in every other state.
REQ-013 WAIT_ECHO: synchronised rising edge -> MEASURE; echo already high without an edge SHALL NOT start measurement; TIMEOUT_CYCLES without edge -> timeout.
REQ-014 MEASURE: divide-free range: sub-counter counts 0..CM_DIV-1, on wrap increments cm counter; cm counter saturates at 255.
REQ-015 MEASURE: synchronised falling edge -> distance_cm = floor(high_cycles/CM_DIV), saturated to 255; dist_valid=1 same cycle distance_cm updates; -> HOLDOFF.
REQ-016 MEASURE: echo high for TIMEOUT_CYCLES -> timeout.
REQ-017 Timeout (either state): distance_cm=8'hFF, dist_err=1 one cycle, dist_valid stays 0, -> HOLDOFF.
REQ-018 HOLDOFF: period counter reaching PERIOD_CYCLES-1 -> TRIG; if already past, -> TRIG next cycle (overrun defers trigger, never drops it).
REQ-019 ena=0 in any state: -> IDLE next cycle, trig_out=0, in-flight measurement discarded, no strobes, distance_cm held.
REQ-020 dist_valid and dist_err SHALL never assert in the same cycle.
REQ-021 Latency: dist_valid asserts 3 clk after echo_in falls (2 sync + 1 register).
REQ-022 All counters sized for parameter maxima; no wrap-around outside saturation rules above.

Reset
REQ-023 rst_n low: state IDLE, trig_out=0, distance_cm=0, dist_valid=0, dist_err=0, busy=0, all counters and synchroniser flops 0.
REQ-024 Reset mid-TRIG SHALL drop trig_out within the reset assertion (asynchronous); first trigger after release follows REQ-011.

Structure
REQ-025 FSM state encoding and default timing constants SHALL live in shared package microgreen_pkg for reuse by the feature/BNN stages.
REQ-026 One sub-module, sync_2ff (two-flop synchroniser with reset), SHALL be instantiated for echo_in.

Verification
REQ-027 Bench params: TRIG_CYCLES=4, CM_DIV=10, PERIOD_CYCLES=2000, TIMEOUT_CYCLES=500.
REQ-028 Normal: echo high 125 cycles after trigger -> distance_cm=12, dist_valid one pulse 3 clk after echo fall, dist_err=0; trig_out high exactly 4 cycles.
REQ-029 No echo: echo_in held low -> after 500 cycles in WAIT_ECHO distance_cm=0xFF, dist_err one pulse; next trig_out rise 2000 cycles after previous.
REQ-030 Saturation/overlong: echo high 499 cycles -> distance_cm=49; echo high 600 cycles -> timeout at 500, distance_cm=0xFF, dist_err pulse.
REQ-031 Stuck-high echo: echo_in high before trigger and stays high -> no dist_valid, timeout after 500 cycles.
REQ-032 ena dropped mid-MEASURE then restored -> no strobe, distance_cm unchanged, trig_out rises one cycle after state returns to TRIG; rst_n pulse mid-TRIG -> trig_out 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/microgreen_pkg.sv
// Shared FSM encoding and default timing constants for the
// HC-SR04 ranger and the downstream feature/BNN stages.
package microgreen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_ECHO,
    ST_MEASURE,
    ST_HOLDOFF
  } ur_state_t;

  localparam int UR_TRIG_CYCLES    = 250;
  localparam int UR_PERIOD_CYCLES  = 1500000;
  localparam int UR_TIMEOUT_CYCLES = 750000;
  localparam int UR_CM_DIV         = 1450;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset.
// Used to bring the raw ECHO pin into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranger: periodic trigger, echo timing, divide-free
// conversion of echo width to centimetres with timeout handling.
module ultrasonic_ranger
  import microgreen_pkg::*;
#(
  parameter int TRIG_CYCLES    = UR_TRIG_CYCLES,
  parameter int PERIOD_CYCLES  = UR_PERIOD_CYCLES,
  parameter int TIMEOUT_CYCLES = UR_TIMEOUT_CYCLES,
  parameter int CM_DIV         = UR_CM_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       echo_in,
  output logic       trig_out,
  output logic [7:0] distance_cm,
  output logic       dist_valid,
  output logic       dist_err,
  output logic       busy
);

  localparam int TW  = cnt_w(TRIG_CYCLES);
  localparam int PW  = cnt_w(PERIOD_CYCLES);
  localparam int TOW = cnt_w(TIMEOUT_CYCLES);
  localparam int SW  = cnt_w(CM_DIV);

  localparam logic [TW-1:0]  TRIG_LAST = TW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0]  PER_LAST  = PW'(PERIOD_CYCLES - 1);
  localparam logic [TOW-1:0] TMO_LAST  = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]  SUB_LAST  = SW'(CM_DIV - 1);

  // Rise cycle already counts as one high cycle.
  localparam logic [SW-1:0]  SUB_INIT  = (CM_DIV == 1) ? '0 : SW'(1);
  localparam logic [7:0]     CM_INIT   = (CM_DIV == 1) ? 8'd1 : 8'd0;

  ur_state_t      r_state;
  logic           r_trig;
  logic [7:0]     r_dist;
  logic           r_valid;
  logic           r_err;
  logic           r_busy;
  logic           r_echo_d;
  logic [TW-1:0]  r_trig_cnt;
  logic [PW-1:0]  r_per;
  logic [TOW-1:0] r_tmo;
  logic [SW-1:0]  r_sub;
  logic [7:0]     r_cm;

  logic w_echo;
  logic w_rise;
  logic w_fall;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (echo_in),
    .o_q   (w_echo)
  );

  assign w_rise = w_echo & ~r_echo_d;
  assign w_fall = ~w_echo & r_echo_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_trig     <= 1'b0;
      r_dist     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_echo_d   <= 1'b0;
      r_trig_cnt <= '0;
      r_per      <= '0;
      r_tmo      <= '0;
      r_sub      <= '0;
      r_cm       <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_echo_d <= w_echo;
      if (r_per != PER_LAST) begin
        r_per <= r_per + 1'b1;
      end
      if (!ena) begin
        r_state <= ST_IDLE;
        r_trig  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_HOLDOFF: begin
            if (r_state == ST_IDLE || r_per == PER_LAST) begin
              r_state    <= ST_TRIG;
              r_trig     <= 1'b1;
              r_busy     <= 1'b1;
              r_per      <= '0;
              r_trig_cnt <= '0;
            end
          end
          ST_TRIG: begin
            if (r_trig_cnt == TRIG_LAST) begin
              r_state <= ST_WAIT_ECHO;
              r_trig  <= 1'b0;
              r_tmo   <= '0;
            end else begin
              r_trig_cnt <= r_trig_cnt + 1'b1;
            end
          end
          ST_WAIT_ECHO: begin
            if (w_rise) begin
              r_state <= ST_MEASURE;
              r_tmo   <= TOW'(1);
              r_sub   <= SUB_INIT;
              r_cm    <= CM_INIT;
            end else if (r_tmo >= TMO_LAST) begin
              r_state <= ST_HOLDOFF;
              r_busy  <= 1'b0;
              r_dist  <= 8'hFF;
              r_err   <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          ST_MEASURE: begin
            if (w_fall) begin
              r_state <= ST_HOLDOFF;
              r_busy  <= 1'b0;
              r_dist  <= r_cm;
              r_valid <= 1'b1;
            end else if (r_tmo >= TMO_LAST) begin
              r_state <= ST_HOLDOFF;
              r_busy  <= 1'b0;
              r_dist  <= 8'hFF;
              r_err   <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
              if (r_sub == SUB_LAST) begin
                r_sub <= '0;
                if (r_cm != 8'hFF) begin
                  r_cm <= r_cm + 1'b1;
                end
              end else begin
                r_sub <= r_sub + 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign trig_out    = r_trig;
  assign distance_cm = r_dist;
  assign dist_valid  = r_valid;
  assign dist_err    = r_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with small timing
// parameters and hand-computed expected values.
module tb_ultrasonic_ranger;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       echo_in;
  logic       trig_out;
  logic [7:0] distance_cm;
  logic       dist_valid;
  logic       dist_err;
  logic       busy;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  logic both_seen = 1'b0;

  ultrasonic_ranger #(
    .TRIG_CYCLES    (4),
    .PERIOD_CYCLES  (2000),
    .TIMEOUT_CYCLES (500),
    .CM_DIV         (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .echo_in     (echo_in),
    .trig_out    (trig_out),
    .distance_cm (distance_cm),
    .dist_valid  (dist_valid),
    .dist_err    (dist_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dist_valid && dist_err) both_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input string tag, input logic lvl);
    int n;
    n = 0;
    while (trig_out !== lvl && n < 4000) begin
      tick(1);
      n++;
    end
    chk(tag, {31'd0, trig_out}, {31'd0, lvl});
  endtask

  task automatic wait_err(input string tag, output logic saw_v);
    int n;
    n = 0;
    saw_v = 1'b0;
    while (dist_err !== 1'b1 && n < 4000) begin
      saw_v = saw_v | dist_valid;
      tick(1);
      n++;
    end
    chk(tag, {31'd0, dist_err}, 32'd1);
  endtask

  initial begin
    int t1;
    int t2;
    int t3;
    int ts;
    int w;
    logic saw_v;
    logic saw_e;

    rst_n   = 1'b0;
    ena     = 1'b0;
    echo_in = 1'b0;
    tick(3);
    chk("rst_trig",  {31'd0, trig_out},   32'd0);
    chk("rst_dist",  {24'd0, distance_cm}, 32'd0);
    chk("rst_valid", {31'd0, dist_valid}, 32'd0);
    chk("rst_err",   {31'd0, dist_err},   32'd0);
    chk("rst_busy",  {31'd0, busy},       32'd0);

    rst_n = 1'b1;
    tick(2);
    chk("idle_trig", {31'd0, trig_out}, 32'd0);
    chk("idle_busy", {31'd0, busy},     32'd0);

    // Normal 125-cycle echo
    ena = 1'b1;
    tick(1);
    chk("trig_rise", {31'd0, trig_out}, 32'd1);
    chk("trig_busy", {31'd0, busy},     32'd1);
    t1 = cyc;
    w = 1;
    tick(1);
    while (trig_out && w < 20) begin
      w++;
      tick(1);
    end
    chk("trig_width", w, 32'd4);
    echo_in = 1'b1;
    tick(125);
    echo_in = 1'b0;
    tick(1);
    chk("lat_1", {31'd0, dist_valid}, 32'd0);
    tick(1);
    chk("lat_2", {31'd0, dist_valid}, 32'd0);
    tick(1);
    chk("lat_3",      {31'd0, dist_valid}, 32'd1);
    chk("dist_12",    {24'd0, distance_cm}, 32'd12);
    chk("norm_err",   {31'd0, dist_err},   32'd0);
    tick(1);
    chk("valid_once", {31'd0, dist_valid}, 32'd0);
    chk("hold_busy",  {31'd0, busy},       32'd0);

    // No echo: WAIT_ECHO timeout
    wait_trig("wait_rise2", 1'b1);
    t2 = cyc;
    chk("period_1", t2 - t1, 32'd2000);
    wait_err("noecho_err", saw_v);
    chk("noecho_time",  cyc - t2, 32'd504);
    chk("noecho_dist",  {24'd0, distance_cm}, 32'hFF);
    chk("noecho_valid", {31'd0, dist_valid}, 32'd0);
    chk("noecho_nov",   {31'd0, saw_v}, 32'd0);
    tick(1);
    chk("noecho_once",  {31'd0, dist_err}, 32'd0);

    // 499-cycle echo
    wait_trig("wait_rise3", 1'b1);
    t3 = cyc;
    chk("period_2", t3 - t2, 32'd2000);
    wait_trig("wait_fall3", 1'b0);
    echo_in = 1'b1;
    tick(499);
    echo_in = 1'b0;
    tick(3);
    chk("v499_valid", {31'd0, dist_valid}, 32'd1);
    chk("v499_dist",  {24'd0, distance_cm}, 32'd49);
    chk("v499_err",   {31'd0, dist_err},   32'd0);

    // ena dropped mid-MEASURE
    wait_trig("wait_rise4", 1'b1);
    wait_trig("wait_fall4", 1'b0);
    echo_in = 1'b1;
    tick(50);
    chk("meas_busy", {31'd0, busy}, 32'd1);
    ena = 1'b0;
    tick(1);
    chk("abort_busy", {31'd0, busy},     32'd0);
    chk("abort_trig", {31'd0, trig_out}, 32'd0);
    echo_in = 1'b0;
    saw_v = 1'b0;
    saw_e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      saw_v = saw_v | dist_valid;
      saw_e = saw_e | dist_err;
      tick(1);
    end
    chk("abort_nov",  {31'd0, saw_v}, 32'd0);
    chk("abort_noe",  {31'd0, saw_e}, 32'd0);
    chk("abort_dist", {24'd0, distance_cm}, 32'd49);
    chk("abort_idle", {31'd0, trig_out}, 32'd0);
    ena = 1'b1;
    tick(1);
    chk("resume_trig", {31'd0, trig_out}, 32'd1);
    t1 = cyc;

    // 600-cycle echo times out in MEASURE
    wait_trig("wait_fall5", 1'b0);
    echo_in = 1'b1;
    ts = cyc;
    wait_err("long_err", saw_v);
    chk("long_time",  cyc - ts, 32'd502);
    chk("long_dist",  {24'd0, distance_cm}, 32'hFF);
    chk("long_nov",   {31'd0, saw_v}, 32'd0);
    chk("long_valid", {31'd0, dist_valid}, 32'd0);
    tick(98);
    echo_in = 1'b0;
    saw_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      saw_v = saw_v | dist_valid;
    end
    chk("long_nolate", {31'd0, saw_v}, 32'd0);

    // Stuck-high echo before trigger
    echo_in = 1'b1;
    wait_trig("wait_rise6", 1'b1);
    t2 = cyc;
    chk("period_3", t2 - t1, 32'd2000);
    wait_err("stuck_err", saw_v);
    chk("stuck_time", cyc - t2, 32'd504);
    chk("stuck_nov",  {31'd0, saw_v}, 32'd0);
    chk("stuck_dist", {24'd0, distance_cm}, 32'hFF);
    echo_in = 1'b0;

    // Asynchronous reset mid-TRIG
    wait_trig("wait_rise7", 1'b1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_trig",  {31'd0, trig_out},   32'd0);
    chk("arst_dist",  {24'd0, distance_cm}, 32'd0);
    chk("arst_valid", {31'd0, dist_valid}, 32'd0);
    chk("arst_err",   {31'd0, dist_err},   32'd0);
    chk("arst_busy",  {31'd0, busy},       32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_trig", {31'd0, trig_out}, 32'd1);
    w = 1;
    tick(1);
    while (trig_out && w < 20) begin
      w++;
      tick(1);
    end
    chk("post_rst_width", w, 32'd4);
    chk("never_both", {31'd0, both_seen}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule
